// File: rtl/inst_fetch_axi_pkg.sv
// Shared constants and FSM encoding for the AXI4-Lite instruction fetch front end.
package inst_fetch_axi_pkg;

   localparam logic [31:0] NOP_INST      = 32'h0;
   localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
   localparam logic [2:0]  ARPROT_INST   = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/inst_fetch_axi.sv
// Instruction fetch front end: one-entry fetch buffer refilled by a single
// outstanding AXI4-Lite read whenever the requested PC misses the buffer.
module inst_fetch_axi
   import inst_fetch_axi_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic [DATA_W-1:0] inst_o,
   output logic              stall_req_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] araddr,
   output logic [2:0]        arprot,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic [1:0]        dbg_state_o
);

   // Handshakes: a beat transfers on the rising edge where valid & ready are
   // both high; once raised, arvalid and araddr hold until that edge, and
   // rready is only raised after the AR beat, so one read is ever in flight.
   fetch_state_t      r_state;
   logic [ADDR_W-1:0] r_araddr;
   logic              r_arvalid;
   logic              r_rready;
   logic              r_err;
   logic [ADDR_W-1:0] r_buf_pc;
   logic [DATA_W-1:0] r_buf_inst;
   logic              r_buf_valid;
   logic              w_hit;

   assign w_hit       = ce_i & r_buf_valid & (r_buf_pc == pc_i);
   assign stall_req_o = ce_i & ~w_hit;
   assign inst_o      = w_hit ? r_buf_inst : DATA_W'(NOP_INST);

   assign araddr      = r_araddr;
   assign arprot      = ARPROT_INST;
   assign arvalid     = r_arvalid;
   assign rready      = r_rready;
   assign err_o       = r_err;
   assign dbg_state_o = r_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_araddr    <= '0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_err       <= 1'b0;
         r_buf_pc    <= '0;
         r_buf_inst  <= '0;
         r_buf_valid <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (ce_i && !w_hit) begin
                  r_araddr  <= pc_i;
                  r_arvalid <= 1'b1;
                  r_state   <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (r_arvalid && arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               // The buffer is tagged with the requested PC, not the current
               // pc_i, so a PC change mid-read simply misses afterwards.
               if (rvalid && r_rready) begin
                  r_buf_pc    <= r_araddr;
                  r_buf_valid <= 1'b1;
                  r_buf_inst  <= (rresp == AXI_RESP_OKAY) ? rdata : DATA_W'(NOP_INST);
                  r_err       <= (rresp != AXI_RESP_OKAY);
                  r_rready    <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
